// File: rtl/add_pkg.sv
// Shared definitions for the pipelined adder/subtractor: opcode encodings
// and the two's-complement overflow expression.
package add_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Signed overflow: operands agree in sign but the result sign differs.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic bx_msb,
                                       input logic sum_msb);
      return (a_msb == bx_msb) && (sum_msb != a_msb);
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice; one per pipeline stage.
module adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit adder/subtractor with the carry chain cut into STAGES registered
// chunks. Operand chunks not yet consumed are skewed forward with the beat and
// finished sum chunks ride along, so every stage holds a complete beat.
// One global enable stalls the whole pipe when the output is blocked.
module pipelined_add_sub
   import add_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int MSB   = WIDTH - 1;
   localparam int LAST  = STAGES - 1;

   logic             w_en;
   logic [WIDTH-1:0] w_bx;
   logic             w_c0;

   // Per-stage registered beat: valid, skewed operands, partial sum, carry.
   logic             r_vld [STAGES];
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_bx  [STAGES];
   logic [WIDTH-1:0] r_sum [STAGES];
   logic             r_c   [STAGES];

   // Whole pipe moves together; it only stops when a result is waiting.
   assign w_en     = !out_valid || out_ready;
   assign in_ready = w_en;

   // Subtract is a + ~b + ~cin, so borrow-in becomes an inverted carry-in.
   assign w_bx = (sub == OP_ADD) ? b : ~b;
   assign w_c0 = (sub == OP_SUB) ? ~cin : cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] w_a_in;
      logic [WIDTH-1:0] w_bx_in;
      logic [WIDTH-1:0] w_sum_in;
      logic             w_c_in;
      logic             w_v_in;
      logic [CHUNK-1:0] w_chunk_sum;
      logic             w_chunk_cout;
      logic [WIDTH-1:0] w_sum_nxt;

      if (k == 0) begin : g_first
         assign w_a_in   = a;
         assign w_bx_in  = w_bx;
         assign w_sum_in = '0;
         assign w_c_in   = w_c0;
         assign w_v_in   = in_valid;
      end else begin : g_rest
         assign w_a_in   = r_a[k-1];
         assign w_bx_in  = r_bx[k-1];
         assign w_sum_in = r_sum[k-1];
         assign w_c_in   = r_c[k-1];
         assign w_v_in   = r_vld[k-1];
      end

      adder_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a    (w_a_in[k*CHUNK +: CHUNK]),
         .b    (w_bx_in[k*CHUNK +: CHUNK]),
         .cin  (w_c_in),
         .sum  (w_chunk_sum),
         .cout (w_chunk_cout)
      );

      // Drop this stage's chunk result into its slot of the travelling sum.
      always_comb begin
         w_sum_nxt = w_sum_in;
         w_sum_nxt[k*CHUNK +: CHUNK] = w_chunk_sum;
      end

      // Stage register: advances only with the global enable.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_vld[k] <= 1'b0;
            r_a[k]   <= '0;
            r_bx[k]  <= '0;
            r_sum[k] <= '0;
            r_c[k]   <= 1'b0;
         end else if (w_en) begin
            r_vld[k] <= w_v_in;
            r_a[k]   <= w_a_in;
            r_bx[k]  <= w_bx_in;
            r_sum[k] <= w_sum_nxt;
            r_c[k]   <= w_chunk_cout;
         end
      end
   end

   assign out_valid = r_vld[LAST];
   assign sum       = r_sum[LAST];
   assign cout      = r_c[LAST];
   assign ovf       = signed_ovf(r_a[LAST][MSB], r_bx[LAST][MSB], r_sum[LAST][MSB]);

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
Parametrised successor to the team's 4-bit ripple full adder: a WIDTH-bit adder/subtractor.
The carry chain is split into STAGES registered chunks, so long words close timing at high clock rates.
Operands enter through a valid/ready handshake, and results leave through one with back-pressure.
Result outputs are sum, carry-out and signed overflow; the block serves as the shared arithmetic unit in datapath pipelines.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages (1..WIDTH); each stage resolves CHUNK = WIDTH/STAGES bits of carry.

Ports:
clk  input  1  sole clock; all state on its rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts operand beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = add, 1 = subtract
cin  input  1  carry-in (add) / borrow-in (sub)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out (add) / NOT borrow-out (sub)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset values: all stage valid bits 0, all data registers 0; so out_valid=0, sum=0, cout=0, ovf=0 while rst_n low and after release.
- Reset mid-operation: in-flight beats are discarded and never emitted; in_ready=1 on the first cycle after release.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Pipeline enable: global en = !out_valid || out_ready; in_ready = en. When en=0 every stage holds, including data and valid bits.
- Bubbles are not collapsed; an empty stage still advances only with en.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall. Throughput is 1 beat/cycle while out_ready=1.
- Arithmetic: effective operand bx = sub ? ~b : b; effective carry c0 = sub ? ~cin : cin.
- Stage k (0-based) adds chunk k of a and bx plus the carry from stage k-1 (c0 for k=0), and registers the chunk sum and carry.
- Operand chunks above k are skewed forward in registers; completed lower sum chunks travel with the beat.
- Result: full result = a + bx + c0 mod 2^WIDTH; cout is the final chunk carry.
- Subtract: sub=1 gives a - b - cin; cout=1 means no borrow.
- ovf = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]). Carry a[MSB] and bx[MSB] through the pipe to compute it.
- Order: results emerge in input order; no beat is dropped or duplicated under any out_ready pattern.
- Simultaneous events: input and output transfer in the same cycle is the normal flow.
- in_valid while in_ready=0 is held by the upstream; the block must not sample it.
- STAGES=1: a single registered full-width adder; latency 1, same handshake.

Decomposition:
- Shared package add_pkg: constants OP_ADD=1'b0 and OP_SUB=1'b1; helper function for the signed-overflow expression.
- One sub-module: adder_chunk, combinational, parameter CHUNK; inputs a, b, cin; outputs sum, cout. Instantiated STAGES times via generate.
- Pipeline registers and handshake live in the top module.

Test Plan:
1. WIDTH=16, STAGES=4, sub=0, cin=0, a=0x7FFF, b=0x0001 -> 4 cycles later out_valid=1, sum=0x8000, cout=0, ovf=1.
2. a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, ovf=0; carry crosses all three stage boundaries.
3. sub=1, cin=0, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
4. Stream 8 back-to-back beats (a=i, b=0x0100*i, add) with out_ready low for 3 cycles mid-stream:
   - in_ready low exactly while out_valid && !out_ready;
   - all 8 results correct and in order, none lost or duplicated.
5. Three beats in flight, then pulse rst_n low asynchronously between edges -> out_valid drops immediately, no stale result after release, in_ready=1.
6. Re-elaborate WIDTH=8, STAGES=1: a=0xF0, b=0x20, cin=1, add -> next cycle sum=0x11, cout=1, ovf=0.
